aes_iter_encrypt_core: RTL and testbench

Multi-cycle AES-128 encryption engine for the execute stage.
- Accepts a 128-bit plaintext and cipher key over a valid/ready handshake.
- Runs the 10 AES rounds iteratively, with the key schedule expanded on the fly.
- Holds the ciphertext until the consumer takes it.
- Parametrised successor to the single-operation AES unit: it sequences SubBytes/ShiftRows/MixColumns/AddRoundKey internally instead of taking an opcode per step.

---
 rtl/aes_iter_encrypt_core.sv | 187 ++++++++++++++++++
 tb/tb_aes_iter_encrypt_core.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_iter_encrypt_core.sv
// aes_iter_encrypt_core: iterative AES-128 encryption engine.
// Accepts plaintext + key, runs ROUNDS_PER_CYCLE rounds per clock with an
// on-the-fly key schedule, and holds the ciphertext until it is consumed.
// Optional build macro AES_ROUND_TRACE_EN adds per-round trace outputs.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and the ciphertext is held stable
// while out_valid is high and out_ready is low.
module aes_iter_encrypt_core #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int NUM_ROUNDS       = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [1:0]   fsm_state
`ifdef AES_ROUND_TRACE_EN
    ,
    output logic         trace_valid,
    output logic [3:0]   trace_round,
    output logic [127:0] trace_state
`endif
);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 5)) begin : g_bad_rounds
        $error("aes_iter_encrypt_core: ROUNDS_PER_CYCLE must be 1, 2 or 5");
    end

    localparam int CW = $clog2(NUM_ROUNDS + ROUNDS_PER_CYCLE + 1);

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;

    state_e          fsm;
    logic [127:0]    state_reg;
    logic [127:0]    rk_reg;
    logic [7:0]      rcon;
    logic [CW-1:0]   rnd;
    logic [127:0]    st_n;
    logic [127:0]    rk_n;
    logic [7:0]      rc_n;
    logic            last_step;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[2047 - 8*int'(x) -: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Next AES-128 round key from the previous one and the current rcon.
    function automatic logic [127:0] next_key(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])} ^ {rc, 24'h0};
        n0 = rk[127:96] ^ t;
        n1 = rk[95:64]  ^ n0;
        n2 = rk[63:32]  ^ n1;
        n3 = rk[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // One full round: SubBytes, ShiftRows, MixColumns (skipped on the last), AddRoundKey.
    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) sb[i] = sbox(st[127 - 8*i -: 8]);
        // Byte index is 4*column + row; row r rotates left by r columns.
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[4*c + r] = sb[4*((c + r) % 4) + r];
        res = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c]; a1 = sr[4*c + 1]; a2 = sr[4*c + 2]; a3 = sr[4*c + 3];
            if (last)
                res[127 - 32*c -: 32] = {a0, a1, a2, a3};
            else
                res[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                         a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                         a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                         xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return res ^ rk;
    endfunction

    // Unrolled round chain: ROUNDS_PER_CYCLE rounds starting at round rnd.
    always_comb begin
        st_n = state_reg;
        rk_n = rk_reg;
        rc_n = rcon;
        for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
            rk_n = next_key(rk_n, rc_n);
            st_n = aes_round(st_n, rk_n, (int'(rnd) + k) == NUM_ROUNDS);
            rc_n = xtime(rc_n);
        end
    end

    assign last_step = (int'(rnd) + ROUNDS_PER_CYCLE) > NUM_ROUNDS;
    assign fsm_state = fsm;

    // Control FSM with registered handshake outputs and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm       <= S_IDLE;
            state_reg <= '0;
            rk_reg    <= '0;
            rcon      <= '0;
            rnd       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        state_reg <= in_data ^ in_key;
                        rk_reg    <= in_key;
                        rcon      <= 8'h01;
                        rnd       <= CW'(1);
                        fsm       <= S_RUN;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_RUN: begin
                    state_reg <= st_n;
                    rk_reg    <= rk_n;
                    rcon      <= rc_n;
                    rnd       <= rnd + CW'(ROUNDS_PER_CYCLE);
                    if (last_step) begin
                        out_data  <= st_n;
                        out_valid <= 1'b1;
                        fsm       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        fsm       <= S_IDLE;
                    end
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

`ifdef AES_ROUND_TRACE_EN
    // Per-edge round trace: shows the rounds completed on the previous RUN edge.
    always_ff @(posedge clk) begin
        if (!rst_n || fsm != S_RUN) begin
            trace_valid <= 1'b0;
            trace_round <= '0;
            trace_state <= '0;
        end else begin
            trace_valid <= 1'b1;
            trace_round <= 4'(int'(rnd) + ROUNDS_PER_CYCLE - 1);
            trace_state <= st_n;
        end
    end
`endif

endmodule

// File: tb/tb_aes_iter_encrypt_core.sv
// Testbench for aes_iter_encrypt_core: three instances (1, 2 and 5 rounds per
// cycle) share clock, reset and data inputs; each has its own handshake lines.
// Expected ciphertexts come from a FIPS-197 style reference model below.
module tb_aes_iter_encrypt_core;

    localparam int RPC [3] = '{1, 2, 5};

    logic         clk;
    logic         rst_n;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_data  [3];
    logic         busy      [3];
    logic [1:0]   fsm_state [3];
`ifdef AES_ROUND_TRACE_EN
    logic         trace_valid [3];
    logic [3:0]   trace_round [3];
    logic [127:0] trace_state [3];
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] sbox_t [256];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_iter_encrypt_core #(.ROUNDS_PER_CYCLE(RPC[g]), .NUM_ROUNDS(10)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data),
            .in_key    (in_key),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g]),
            .fsm_state (fsm_state[g])
`ifdef AES_ROUND_TRACE_EN
            ,
            .trace_valid (trace_valid[g]),
            .trace_round (trace_round[g]),
            .trace_state (trace_state[g])
`endif
        );
    end

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then the affine map.
    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_t[x] = s;
        end
    endtask

    // State after n rounds (n = 10 gives the ciphertext).
    function automatic logic [127:0] ref_after(input logic [127:0] pt, input logic [127:0] key,
                                               input int n);
        logic [31:0]  w [44];
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
                      ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127 - 8*(4*c + r) -: 8] ^ w[c][31 - 8*r -: 8];
        for (int rd = 1; rd <= n; rd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sbox_t[s[r][(c + r) % 4]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    if (rd < 10)
                        s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c])
                                  ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
                    else
                        s[r][c] = t[r][c];
                    s[r][c] ^= w[4*rd + c][31 - 8*r -: 8];
                end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127 - 8*(4*c + r) -: 8] = s[r][c];
        return res;
    endfunction

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- driver tasks ----------------
    // Present a block on unit u and wait until it is taken; inputs are then scrambled.
    task automatic accept(input int u, input logic [127:0] pt, input logic [127:0] key);
        bit taken = 0;
        in_valid[u] = 1'b1;
        in_data     = pt;
        in_key      = key;
        for (int i = 0; i < 40 && !taken; i++) begin
            if (in_ready[u]) taken = 1;
            @(posedge clk); #1;
        end
        if (!taken) check("accept_timeout", 0, 1);
        in_valid[u] = 1'b0;
        in_data     = rand128();
        in_key      = rand128();
    endtask

    // Wait for out_valid, checking latency, data and status at that point.
    task automatic collect(input int u, input logic [127:0] exp, input bit churn, input string tag);
        int n = 0;
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (churn) begin
                in_data = rand128();
                in_key  = rand128();
            end
            @(posedge clk); #1;
            n++;
            if (out_valid[u]) seen = 1;
            else check({tag, "_busy_run"}, 128'(busy[u]), 128'd1);
        end
        check({tag, "_latency"}, 128'(n), 128'(10 / RPC[u]));
        check({tag, "_data"}, out_data[u], exp);
        check({tag, "_in_ready_done"}, 128'(in_ready[u]), 128'd0);
    endtask

    // Optional stall, then output handshake; in_ready must rise right after it.
    task automatic finish_hs(input int u, input logic [127:0] exp, input int stall, input string tag);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 128'(out_valid[u]), 128'd1);
            check({tag, "_hold_data"}, out_data[u], exp);
        end
        out_ready[u] = 1'b1;
        @(posedge clk); #1;
        check({tag, "_hs_valid"}, 128'(out_valid[u]), 128'd0);
        check({tag, "_hs_in_ready"}, 128'(in_ready[u]), 128'd1);
        check({tag, "_hs_busy"}, 128'(busy[u]), 128'd0);
        check({tag, "_hs_data_kept"}, out_data[u], exp);
    endtask

    task automatic run_block(input int u, input logic [127:0] pt, input logic [127:0] key,
                             input bit churn, input int stall, input string tag);
        logic [127:0] exp = ref_after(pt, key, 10);
        accept(u, pt, key);
        out_ready[u] = (stall == 0);
        collect(u, exp, churn, tag);
        finish_hs(u, exp, stall, tag);
    endtask

    // ---------------- directed + random sequence ----------------
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

    initial begin
        logic [127:0] pt, key, exp_a, exp_b;
        rst_n   = 1'b0;
        in_data = '0;
        in_key  = '0;
        for (int u = 0; u < 3; u++) begin
            in_valid[u]  = 1'b0;
            out_ready[u] = 1'b1;
        end
        build_sbox();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            check($sformatf("reset_out_valid_u%0d", u), 128'(out_valid[u]), 128'd0);
            check($sformatf("reset_out_data_u%0d", u), out_data[u], 128'd0);
            check($sformatf("reset_busy_u%0d", u), 128'(busy[u]), 128'd0);
            check($sformatf("reset_in_ready_u%0d", u), 128'(in_ready[u]), 128'd1);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Known-answer vector, one round per cycle
        accept(0, PT_C1, KEY_C1);
        collect(0, CT_C1, 0, "kat_c1_r1");
        finish_hs(0, CT_C1, 0, "kat_c1_r1");

        // Known-answer vector with 2 and 5 rounds per cycle
        for (int u = 1; u < 3; u++) begin
            accept(u, PT_B, KEY_B);
            collect(u, CT_B, 0, $sformatf("kat_b_r%0d", RPC[u]));
            finish_hs(u, CT_B, 0, $sformatf("kat_b_r%0d", RPC[u]));
        end

        // Input churn during RUN must not disturb the accepted block
        accept(0, PT_C1, KEY_C1);
        collect(0, CT_C1, 1, "churn");
        finish_hs(0, CT_C1, 0, "churn");

        // Backpressure: ciphertext held, second request refused until handshake
        pt    = rand128();
        key   = rand128();
        exp_a = ref_after(pt, key, 10);
        accept(0, pt, key);
        out_ready[0] = 1'b0;
        collect(0, exp_a, 0, "bp_first");
        pt    = rand128();
        key   = rand128();
        exp_b = ref_after(pt, key, 10);
        in_valid[0] = 1'b1;
        in_data     = pt;
        in_key      = key;
        for (int s = 0; s < 7; s++) begin
            @(posedge clk); #1;
            check("bp_hold_data", out_data[0], exp_a);
            check("bp_hold_valid", 128'(out_valid[0]), 128'd1);
            check("bp_in_ready_low", 128'(in_ready[0]), 128'd0);
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 128'(out_valid[0]), 128'd0);
        check("bp_release_in_ready", 128'(in_ready[0]), 128'd1);
        accept(0, pt, key);
        collect(0, exp_b, 0, "bp_second");
        finish_hs(0, exp_b, 0, "bp_second");

        // Reset in the middle of RUN aborts the block
        accept(0, PT_C1, KEY_C1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_out_valid", 128'(out_valid[0]), 128'd0);
        check("midrst_out_data", out_data[0], 128'd0);
        check("midrst_busy", 128'(busy[0]), 128'd0);
        check("midrst_in_ready", 128'(in_ready[0]), 128'd1);
        run_block(0, rand128(), rand128(), 0, 0, "after_rst");

        // Randomized blocks across all three configurations
        for (int it = 0; it < 12; it++) begin
            run_block(it % 3, rand128(), rand128(), bit'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $sformatf("rand%0d_r%0d", it, RPC[it % 3]));
        end

`ifdef AES_ROUND_TRACE_EN
        // Round trace, one round per cycle
        accept(0, PT_B, KEY_B);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            check($sformatf("trace_valid_%0d", k), 128'(trace_valid[0]), 128'd1);
            check($sformatf("trace_round_%0d", k), 128'(trace_round[0]), 128'(k));
            check($sformatf("trace_state_%0d", k), trace_state[0], ref_after(PT_B, KEY_B, k));
            if (k == 1)
                check("trace_state_round1_kat", trace_state[0],
                      128'ha49c7ff2689f352b6b5bea43026a5049);
        end
        check("trace_out_valid", 128'(out_valid[0]), 128'd1);
        check("trace_out_data", out_data[0], CT_B);
        finish_hs(0, CT_B, 0, "trace");
        check("trace_idle_valid", 128'(trace_valid[0]), 128'd0);
        check("trace_idle_state", trace_state[0], 128'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
